// File: rtl/sram_pkg.sv
// Shared constants and word type for the single-port SRAM.
// Defaults: SRAM_WIDTH_DEF (word width), SRAM_LENGTH_DEF (word count).
package sram_pkg;

    localparam int unsigned SRAM_WIDTH_DEF  = 32;
    localparam int unsigned SRAM_LENGTH_DEF = 256;

    // Word type for users of sram_sp at the default width
    typedef logic [SRAM_WIDTH_DEF-1:0] sram_word_t;

endpackage : sram_pkg

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM with registered, write-first read data.
// Ports:
//   clk      - clock, all updates on rising edge
//   res      - synchronous active-high reset (clears data_out, blocks writes)
//   WE       - 1 = write data_in to mem[addr], 0 = read mem[addr]
//   addr     - word address
//   data_in  - write data
//   data_out - registered read data, one cycle latency
// Optional macro SRAM_CLEAR_ON_RESET_EN: reset also zeroes every memory word.
module sram_sp
    import sram_pkg::*;
#(
    parameter  int unsigned WIDTH  = SRAM_WIDTH_DEF,
    parameter  int unsigned LENGTH = SRAM_LENGTH_DEF,
    localparam int unsigned ADDR_W = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              WE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out
);

    logic [WIDTH-1:0] mem [LENGTH];

`ifdef SRAM_CLEAR_ON_RESET_EN
    // Array and output register share one reset so the whole array clears in one edge
    always_ff @(posedge clk) begin
        if (res) begin
            data_out <= '0;
            for (int i = 0; i < int'(LENGTH); i++) begin
                mem[i] <= '0;
            end
        end else if (WE) begin
            mem[addr] <= data_in;
            data_out  <= data_in;
        end else begin
            data_out <= mem[addr];
        end
    end
`else
    // Array write port: no reset term so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (!res && WE) begin
            mem[addr] <= data_in;
        end
    end

    // Output register: write-first forwarding of data_in on writes
    always_ff @(posedge clk) begin
        if (res) begin
            data_out <= '0;
        end else if (WE) begin
            data_out <= data_in;
        end else begin
            data_out <= mem[addr];
        end
    end
`endif

endmodule : sram_sp

// File: tb/tb_sram_sp.sv
// Randomized self-checking bench for sram_sp against an array-based model.
module tb_sram_sp;

    logic        clk;
    logic        res;
    logic        WE;
    logic [7:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int total;
    int bad;

    // Reference model: word contents plus a flag saying the word holds a defined value
    logic [31:0] mem_m [256];
    bit          known [256];
    logic [31:0] prev_exp;
    bit          prev_chk;

    sram_sp dut (
        .clk      (clk),
        .res      (res),
        .WE       (WE),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the model predicts data_out after the edge
    task automatic do_op(input string tag, input logic r, input logic w,
                         input logic [7:0] a, input logic [31:0] d);
        logic [31:0] e;
        bit          chk;
        @(negedge clk);
        res = r; WE = w; addr = a; data_in = d;
        #1;
        // data_out must not react to new inputs before the edge
        if (prev_chk) check("hold", data_out, prev_exp);
        chk = 1'b1;
        e   = '0;
        if (r) begin
            e = '0;
`ifdef SRAM_CLEAR_ON_RESET_EN
            for (int i = 0; i < 256; i++) begin
                mem_m[i] = '0;
                known[i] = 1'b1;
            end
`endif
        end else if (w) begin
            mem_m[a] = d;
            known[a] = 1'b1;
            e        = d;
        end else begin
            chk = known[a];
            e   = mem_m[a];
        end
        @(posedge clk);
        #1;
        if (chk) check(tag, data_out, e);
        prev_exp = e;
        prev_chk = chk;
    endtask

    initial begin
        logic [31:0] v;
        total    = 0;
        bad      = 0;
        prev_chk = 1'b0;
        prev_exp = '0;
        for (int i = 0; i < 256; i++) begin
            known[i] = 1'b0;
            mem_m[i] = '0;
        end
        res = 1'b1; WE = 1'b1; addr = 8'd5; data_in = 32'hFFFF_FFFF;

        // Reset held with a pending write
        for (int i = 0; i < 3; i++) do_op("reset", 1'b1, 1'b1, 8'd5, 32'hFFFF_FFFF);
        do_op("reset_no_write", 1'b0, 1'b0, 8'd5, 32'h0);

        // Write then read
        do_op("wr0", 1'b0, 1'b1, 8'd0, 32'h0001_8000);
        do_op("rd0", 1'b0, 1'b0, 8'd0, 32'h0);

        // Write-first visibility
        do_op("wf3", 1'b0, 1'b1, 8'd3, 32'h0004_1000);

        // Walking-bit sweep over the low 32 addresses
        for (int i = 0; i < 32; i++) begin
            if (i <= 15) v = (32'd1 << (15 - i)) | (32'd1 << (15 + i));
            else         v = (32'd1 << (i - 15)) | (32'd1 << (46 - i));
            do_op("sweep_wr", 1'b0, 1'b1, 8'(i), v);
        end
        for (int i = 0; i < 32; i++) do_op("sweep_rd", 1'b0, 1'b0, 8'(i), 32'h0);

        // Address extremes
        do_op("top_wr", 1'b0, 1'b1, 8'd255, 32'hDEAD_BEEF);
        do_op("bot_wr", 1'b0, 1'b1, 8'd0,   32'h1234_5678);
        do_op("top_rd", 1'b0, 1'b0, 8'd255, 32'h0);
        do_op("bot_rd", 1'b0, 1'b0, 8'd0,   32'h0);

        // Reset on a write edge drops the write
        do_op("pre7_wr",  1'b0, 1'b1, 8'd7, 32'hA5A5_0007);
        do_op("mid_rst",  1'b1, 1'b1, 8'd7, 32'h5A5A_FFFF);
        do_op("post7_rd", 1'b0, 1'b0, 8'd7, 32'h0);

        // Random traffic, concentrated on a small window to revisit addresses
        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic       w;
            logic [7:0] a;
            r = ($urandom_range(0, 39) == 0);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            do_op("rand", r, w, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sram_sp
